cicero_job_loader: RTL and testbench
====================================

# cicero_job_loader

Hardware job sequencer that sits directly upstream of `AXI_top` and drives its register-command interface. It consumes a valid/ready word stream carrying one regex job (a header word, then code words, then string bytes packed into words) and writes code and string into the engine memory with `CMD_WRITE`. It then issues `CMD_START`, waits for accept or reject, reads the elapsed clock count, and returns a result record on a valid/ready output.

## Interface

Parameters:
- `MEM_WORDS`, 1024: engine memory depth in 32-bit words; jobs exceeding it are rejected.
- `START_TIMEOUT`, 16: cycles allowed for `status_register` to reach `STATUS_RUNNING` after `CMD_START`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  REG_WIDTH  job stream word.
- `s_valid`  in  1  stream word valid.
- `s_last`  in  1  marks the final word of the job.
- `s_ready`  out  1  stream word accepted when `s_valid && s_ready`.
- `address_register`  out  REG_WIDTH  to `AXI_top`; word address.
- `data_in_register`  out  REG_WIDTH  to `AXI_top`; write data.
- `start_cc_pointer_register`  out  REG_WIDTH  to `AXI_top`; first string byte address.
- `end_cc_pointer_register`  out  REG_WIDTH  to `AXI_top`; last string byte address.
- `cmd_register`  out  REG_WIDTH  to `AXI_top`; command.
- `status_register`  in  REG_WIDTH  from `AXI_top`.
- `data_o_register`  in  REG_WIDTH  from `AXI_top`.
- `r_valid`  out  1  result valid.
- `r_ready`  in  1  result consumed when `r_valid && r_ready`.
- `r_accept`  out  1  1 = string accepted.
- `r_error`  out  1  1 = malformed job or start timeout; `r_accept` is 0 when set.
- `r_cycles`  out  REG_WIDTH  elapsed clock count from the engine; 0 on error.
- `busy`  out  1  high in every state except IDLE.

## Operation

- Header word layout: `[31:16]` = code_words (C), `[15:0]` = string_bytes (S).
- String word count is W = ceil(S/4). Bytes are little-endian: byte 0 is in `[7:0]`. Pad bytes are don't-care.
- Header is rejected (go to DRAIN, then ERR) if any of these holds: C = 0; S = 0; C + W > MEM_WORDS; or header carries `s_last`.
- Code word i is written to address i. String word j is written to address C + j.
- Start pointers are `start_cc = 4*C` and `end_cc = 4*C + S - 1`. Arithmetic is REG_WIDTH unsigned.
- `s_last` must arrive exactly on string word W-1. Earlier `s_last` → ERR (no START). Missing `s_last` on word W-1 → DRAIN until `s_last`, then ERR.

States:
- IDLE: `s_ready`=1. Accepts the header; goes to SETUP.
- SETUP: `s_ready`=1, `cmd`=NOP. On handshake, latch address and data; go to STROBE.
- STROBE: `cmd`=`CMD_WRITE` for one cycle. Returns to SETUP, or goes to START after the last word.
- START: drive pointers and `cmd`=`CMD_START`. Hold until `status==STATUS_RUNNING`, then go to WAIT. If `START_TIMEOUT` cycles elapse first, go to ERR.
- WAIT: `cmd`=NOP. On `STATUS_ACCEPTED` or `STATUS_REJECTED`, latch `r_accept` and go to RDCC.
- RDCC: `cmd`=`CMD_READ_ELAPSED_CLOCK` for one cycle, then CAP.
- CAP: `r_cycles <= data_o_register`; go to RESULT.
- DRAIN: `s_ready`=1; discard words until `s_last`; go to ERR.
- ERR: set `r_error`; go to RESULT.
- RESULT: `r_valid`=1; outputs held stable until `r_ready`; then CLEAR.
- CLEAR: `cmd`=`CMD_RESET` for one cycle, then IDLE.

## Timing

- All outputs are registered.
- Reset values: every REG_WIDTH output is 0 and `cmd_register`=`CMD_NOP`; `s_ready`, `r_valid`, `r_accept`, `r_error` and `busy` are all 0.
- After reset deasserts, IDLE raises `s_ready` on the next edge.
- Throughput is 2 cycles per word minimum. `cmd` is NOP in every cycle outside STROBE, START, RDCC and CLEAR.
- `address_register` and `data_in_register` change only on a SETUP handshake, so they are stable for the full STROBE cycle.
- START to `CMD_START` to status: RUNNING is sampled at the earliest on the first cycle after `cmd` updates.
- The timeout counter saturates. RUNNING and timeout in the same cycle → RUNNING wins.
- If status is ACCEPTED or REJECTED while in START (a very fast job), go straight to RDCC.
- A new job is not accepted until CLEAR completes.
- Reset asserted mid-job: all state returns to reset values immediately, with no CLEAR issued. The system resets `AXI_top` alongside this block.

## Structure

- Add to the shared package: `loader_state_t` enum; header field offsets (`HDR_CODE_LSB=16`, `HDR_STR_LSB=0`); and the result record struct `{accept, error, cycles}`.
- Reuse `AXI_package` for `CMD_*`, `STATUS_*` and `REG_WIDTH`.
- Single module. Header decode and bounds check stay inline; no sub-module is warranted.

## Test plan

- Header {3,5}, 3 code words, 2 string words with `s_last` on the last one; engine model returns ACCEPTED and 0x2A cycles → `CMD_WRITE` at addresses 0..4; `start_cc`=12, `end_cc`=16; result accept=1, error=0, cycles=0x2A; then `CMD_RESET`.
- Same job with the model returning REJECTED → accept=0, error=0, cycles = the model value.
- Header {3,5} with `s_last` on code word 1 → no `CMD_START`; result error=1; next job runs normally.
- Header {0,4} followed by 2 words, the last with `s_last` → both words drained, zero `CMD_WRITE`, error=1.
- Status never RUNNING → `CMD_START` held exactly 16 cycles, then error=1 and cycles=0.
- `r_ready` held low 10 cycles → result outputs stable throughout. Separately, `rst` low during WAIT → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/AXI_package.sv
// Register-command encodings and word width shared with the AXI_top engine.
package AXI_package;

  localparam int REG_WIDTH = 32;

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_READ               = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd4;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd5;

  localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

endpackage

// File: rtl/cicero_job_loader_pkg.sv
// Job loader types: sequencer states, header field layout and the result record.
package cicero_job_loader_pkg;
  import AXI_package::*;

  localparam int HDR_CODE_LSB = 16;
  localparam int HDR_STR_LSB  = 0;
  localparam int HDR_FIELD_W  = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_START,
    ST_WAIT,
    ST_RDCC,
    ST_CAP,
    ST_DRAIN,
    ST_ERR,
    ST_RESULT,
    ST_CLEAR
  } loader_state_t;

  typedef struct packed {
    logic                 accept;
    logic                 error;
    logic [REG_WIDTH-1:0] cycles;
  } result_t;

  // Number of 32-bit words needed to hold a byte count (ceil(bytes/4)).
  function automatic logic [HDR_FIELD_W-1:0] str_words(input logic [HDR_FIELD_W-1:0] bytes);
    logic [HDR_FIELD_W:0] sum;
    sum = {1'b0, bytes} + 17'd3;
    return {1'b0, sum[HDR_FIELD_W:2]};
  endfunction

endpackage

// File: rtl/cicero_job_loader.sv
// Streams one regex job (header, code words, string words) into AXI_top,
// runs it, and returns {accept, error, cycles} on a valid/ready result port.
module cicero_job_loader
  import AXI_package::*;
  import cicero_job_loader_pkg::*;
#(
  parameter int MEM_WORDS     = 1024,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic                 r_accept,
  output logic                 r_error,
  output logic [REG_WIDTH-1:0] r_cycles,
  output logic                 busy
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int CW = HDR_FIELD_W + 1;

  loader_state_t          state, state_nx;
  logic [HDR_FIELD_W-1:0] code_words, code_words_nx;
  logic [HDR_FIELD_W-1:0] str_bytes, str_bytes_nx;
  logic [CW-1:0]          total, total_nx;
  logic [CW-1:0]          idx, idx_nx;
  logic [TW-1:0]          tcnt, tcnt_nx;
  logic [REG_WIDTH-1:0]   address_nx, data_in_nx, start_cc_nx, end_cc_nx, cmd_nx;
  result_t                res, res_nx;
  logic                   s_ready_nx, r_valid_nx, busy_nx;

  logic                   s_hs, r_hs;
  logic [HDR_FIELD_W-1:0] hdr_code, hdr_str, hdr_words;
  logic [REG_WIDTH-1:0]   hdr_span;
  logic                   hdr_bad, last_word, status_running, status_done;

  assign s_hs           = s_valid && s_ready;
  assign r_hs           = r_valid && r_ready;
  assign hdr_code       = s_data[HDR_CODE_LSB +: HDR_FIELD_W];
  assign hdr_str        = s_data[HDR_STR_LSB +: HDR_FIELD_W];
  assign hdr_words      = str_words(hdr_str);
  assign hdr_span       = REG_WIDTH'(hdr_code) + REG_WIDTH'(hdr_words);
  assign hdr_bad        = (hdr_code == 16'd0) || (hdr_str == 16'd0) ||
                          (hdr_span > REG_WIDTH'(MEM_WORDS)) || s_last;
  assign last_word      = (idx == (total - CW'(1)));
  assign status_running = (status_register == STATUS_RUNNING);
  assign status_done    = (status_register == STATUS_ACCEPTED) ||
                          (status_register == STATUS_REJECTED);

  // Next-state and next-value logic for every register of the sequencer.
  always_comb begin
    state_nx      = state;
    code_words_nx = code_words;
    str_bytes_nx  = str_bytes;
    total_nx      = total;
    idx_nx        = idx;
    tcnt_nx       = tcnt;
    address_nx    = address_register;
    data_in_nx    = data_in_register;
    start_cc_nx   = start_cc_pointer_register;
    end_cc_nx     = end_cc_pointer_register;
    res_nx        = res;
    case (state)
      ST_IDLE: begin
        if (s_hs) begin
          code_words_nx = hdr_code;
          str_bytes_nx  = hdr_str;
          total_nx      = CW'(hdr_code) + CW'(hdr_words);
          idx_nx        = '0;
          // A bad header that already ends the job has nothing left to drain.
          if (!hdr_bad) begin
            state_nx = ST_SETUP;
          end else if (s_last) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_DRAIN;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (s_hs) begin
          if (last_word == s_last) begin
            address_nx = REG_WIDTH'(idx);
            data_in_nx = s_data;
            idx_nx     = idx + CW'(1);
            state_nx   = ST_STROBE;
          end else if (s_last) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_DRAIN;
          end
        end else begin
          state_nx = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (idx == total) begin
          tcnt_nx     = '0;
          start_cc_nx = REG_WIDTH'({code_words, 2'b00});
          end_cc_nx   = REG_WIDTH'({code_words, 2'b00}) + REG_WIDTH'(str_bytes) - REG_WIDTH'(1);
          state_nx    = ST_START;
        end else begin
          state_nx = ST_SETUP;
        end
      end
      ST_START: begin
        if (status_running) begin
          state_nx = ST_WAIT;
        end else if (status_done) begin
          res_nx.accept = (status_register == STATUS_ACCEPTED);
          state_nx      = ST_RDCC;
        end else if (tcnt == TW'(START_TIMEOUT - 1)) begin
          state_nx = ST_ERR;
        end else begin
          tcnt_nx = (tcnt == {TW{1'b1}}) ? tcnt : tcnt + TW'(1);
        end
      end
      ST_WAIT: begin
        if (status_done) begin
          res_nx.accept = (status_register == STATUS_ACCEPTED);
          state_nx      = ST_RDCC;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_RDCC: state_nx = ST_CAP;
      ST_CAP: begin
        res_nx.cycles = data_o_register;
        state_nx      = ST_RESULT;
      end
      ST_DRAIN: begin
        if (s_hs && s_last) begin
          state_nx = ST_ERR;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      ST_ERR: begin
        res_nx   = '{accept: 1'b0, error: 1'b1, cycles: '0};
        state_nx = ST_RESULT;
      end
      ST_RESULT: begin
        if (r_hs) begin
          res_nx   = '0;
          state_nx = ST_CLEAR;
        end else begin
          state_nx = ST_RESULT;
        end
      end
      ST_CLEAR: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Handshake and command outputs are decoded from the upcoming state so they register cleanly.
  always_comb begin
    s_ready_nx = (state_nx == ST_IDLE) || (state_nx == ST_SETUP) || (state_nx == ST_DRAIN);
    r_valid_nx = (state_nx == ST_RESULT);
    busy_nx    = (state_nx != ST_IDLE);
    case (state_nx)
      ST_STROBE: cmd_nx = CMD_WRITE;
      ST_START:  cmd_nx = CMD_START;
      ST_RDCC:   cmd_nx = CMD_READ_ELAPSED_CLOCK;
      ST_CLEAR:  cmd_nx = CMD_RESET;
      default:   cmd_nx = CMD_NOP;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                     <= ST_IDLE;
      code_words                <= '0;
      str_bytes                 <= '0;
      total                     <= '0;
      idx                       <= '0;
      tcnt                      <= '0;
      address_register          <= '0;
      data_in_register          <= '0;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      cmd_register              <= CMD_NOP;
      res                       <= '0;
      s_ready                   <= 1'b0;
      r_valid                   <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      state                     <= state_nx;
      code_words                <= code_words_nx;
      str_bytes                 <= str_bytes_nx;
      total                     <= total_nx;
      idx                       <= idx_nx;
      tcnt                      <= tcnt_nx;
      address_register          <= address_nx;
      data_in_register          <= data_in_nx;
      start_cc_pointer_register <= start_cc_nx;
      end_cc_pointer_register   <= end_cc_nx;
      cmd_register              <= cmd_nx;
      res                       <= res_nx;
      s_ready                   <= s_ready_nx;
      r_valid                   <= r_valid_nx;
      busy                      <= busy_nx;
    end
  end

  assign r_accept = res.accept;
  assign r_error  = res.error;
  assign r_cycles = res.cycles;

endmodule

// File: tb/tb_cicero_job_loader.sv
// Directed bench for cicero_job_loader: a small engine model answers the
// command port, a job-level model predicts writes, pointers and results.
module tb_cicero_job_loader;
  import AXI_package::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] address_register, data_in_register, start_cc_pointer_register;
  logic [31:0] end_cc_pointer_register, cmd_register, r_cycles;
  logic [31:0] status_register, data_o_register;
  logic        r_valid, r_ready = 1'b0, r_accept, r_error, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cicero_job_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .address_register(address_register),
    .data_in_register(data_in_register),
    .start_cc_pointer_register(start_cc_pointer_register),
    .end_cc_pointer_register(end_cc_pointer_register), .cmd_register(cmd_register),
    .status_register(status_register), .data_o_register(data_o_register),
    .r_valid(r_valid), .r_ready(r_ready), .r_accept(r_accept), .r_error(r_error),
    .r_cycles(r_cycles), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: mode 0 accept, 1 reject, 2 never running, 3 instant accept, 4 runs forever.
  int          eng_mode = 0;
  logic [31:0] eng_cycles = 32'd0;
  int          run_cnt = 0;
  bit          eng_run = 1'b0;
  int          n_write = 0, n_start = 0, n_rdcc = 0, n_reset = 0;
  logic [31:0] mem [0:63];

  initial begin
    status_register = STATUS_IDLE;
    data_o_register = 32'hDEAD_0000;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        status_register = STATUS_IDLE;
        eng_run = 1'b0;
      end else begin
        if (eng_run) begin
          run_cnt++;
          if (run_cnt == 3) begin
            status_register = (eng_mode == 1) ? STATUS_REJECTED : STATUS_ACCEPTED;
            eng_run = 1'b0;
          end
        end
        case (cmd_register)
          CMD_WRITE: begin
            n_write++;
            if (address_register < 32'd64) mem[address_register[5:0]] = data_in_register;
          end
          CMD_START: begin
            n_start++;
            if (status_register == STATUS_IDLE) begin
              if (eng_mode == 0 || eng_mode == 1 || eng_mode == 4) begin
                status_register = STATUS_RUNNING;
                eng_run = (eng_mode != 4);
                run_cnt = 0;
              end else if (eng_mode == 3) begin
                status_register = STATUS_ACCEPTED;
              end
            end
          end
          CMD_READ_ELAPSED_CLOCK: begin
            n_rdcc++;
            data_o_register = eng_cycles;
          end
          CMD_RESET: begin
            n_reset++;
            status_register = STATUS_IDLE;
            data_o_register = 32'hDEAD_0000;
          end
          default: ;
        endcase
      end
    end
  end

  // Job model: predicted writes, pointers and result record.
  logic [31:0] wq[$];
  bit          lq[$];
  logic [31:0] exp_wr_addr[$], exp_wr_data[$];
  logic [31:0] exp_start_cc = 32'd0, exp_end_cc = 32'd0, exp_cyc = 32'd0;
  bit          exp_acc = 1'b0, exp_err = 1'b0, exp_ok = 1'b0, exp_timeout = 1'b0;
  int          exp_n_writes = 0;
  bit          cmp_en = 1'b0;
  logic [31:0] seen_cyc = 32'd0;
  bit          seen_acc = 1'b0, seen_err = 1'b0;

  task automatic clear_job();
    wq.delete();
    lq.delete();
  endtask

  task automatic add_word(input logic [31:0] w, input bit l);
    wq.push_back(w);
    lq.push_back(l);
  endtask

  task automatic plan(input int mode, input logic [31:0] cyc);
    int c, s, w, total;
    bit bad;
    c = int'(wq[0][31:16]);
    s = int'(wq[0][15:0]);
    w = (s + 3) / 4;
    total = c + w;
    bad = (c == 0) || (s == 0) || (total > 1024) || lq[0];
    exp_ok = !bad;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    if (!bad) begin
      for (int i = 1; i < wq.size(); i++) begin
        if (i - 1 == total - 1) begin
          if (lq[i]) begin
            exp_wr_addr.push_back(32'(i - 1));
            exp_wr_data.push_back(wq[i]);
          end else begin
            exp_ok = 1'b0;
          end
          break;
        end
        if (lq[i]) begin
          exp_ok = 1'b0;
          break;
        end
        exp_wr_addr.push_back(32'(i - 1));
        exp_wr_data.push_back(wq[i]);
      end
    end
    exp_n_writes = exp_wr_addr.size();
    exp_start_cc = 32'(4 * c);
    exp_end_cc   = 32'(4 * c + s - 1);
    exp_timeout  = exp_ok && (mode == 2);
    if (exp_ok && mode != 2) begin
      exp_acc = (mode != 1);
      exp_err = 1'b0;
      exp_cyc = cyc;
    end else begin
      exp_acc = 1'b0;
      exp_err = 1'b1;
      exp_cyc = 32'd0;
    end
  endtask

  // Per-cycle comparison of the command port and result port against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && cmp_en) begin
        if (cmd_register == CMD_WRITE) begin
          if (exp_wr_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                     address_register, data_in_register);
          end else begin
            chk("write_addr", address_register, exp_wr_addr.pop_front());
            chk("write_data", data_in_register, exp_wr_data.pop_front());
          end
        end
        if (cmd_register == CMD_START) begin
          chk("start_cc", start_cc_pointer_register, exp_start_cc);
          chk("end_cc", end_cc_pointer_register, exp_end_cc);
        end
        if (r_valid) begin
          chk("r_accept", r_accept, exp_acc);
          chk("r_error", r_error, exp_err);
          chk("r_cycles", r_cycles, exp_cyc);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit l);
    int t;
    t = 0;
    @(negedge clk);
    s_data = w;
    s_valid = 1'b1;
    s_last = l;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: word 0x%0h not accepted within 100 cycles", w);
    end else begin
      @(posedge clk);
    end
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic run_job(input int mode, input logic [31:0] cyc, input int hold, input string tag);
    int t, n0w, n0s, n0r, n0c;
    eng_mode = mode;
    eng_cycles = cyc;
    plan(mode, cyc);
    n0w = n_write; n0s = n_start; n0r = n_rdcc; n0c = n_reset;
    cmp_en = 1'b1;
    foreach (wq[i]) send_word(wq[i], lq[i]);
    t = 0;
    while (!r_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_r_valid_seen"}, r_valid, 1);
    seen_acc = r_accept;
    seen_err = r_error;
    seen_cyc = r_cycles;
    if (r_valid) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({tag, "_r_valid_held"}, r_valid, 1);
      end
      @(negedge clk);
      r_ready = 1'b1;
      @(posedge clk);
      #1;
      r_ready = 1'b0;
    end
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_writes_left"}, exp_wr_addr.size(), 0);
    chk({tag, "_n_write"}, n_write - n0w, exp_n_writes);
    if (exp_timeout) chk({tag, "_start_cycles"}, n_start - n0s, 16);
    else if (exp_ok) chk({tag, "_start_issued"}, (n_start - n0s) > 0, 1);
    else chk({tag, "_no_start"}, n_start - n0s, 0);
    chk({tag, "_n_rdcc"}, n_rdcc - n0r, (exp_ok && !exp_timeout) ? 1 : 0);
    chk({tag, "_n_reset"}, n_reset - n0c, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_addr"}, address_register, 0);
    chk({tag, "_data_in"}, data_in_register, 0);
    chk({tag, "_start_cc"}, start_cc_pointer_register, 0);
    chk({tag, "_end_cc"}, end_cc_pointer_register, 0);
    chk({tag, "_cmd"}, cmd_register, CMD_NOP);
    chk({tag, "_r_valid"}, r_valid, 0);
    chk({tag, "_r_accept"}, r_accept, 0);
    chk({tag, "_r_error"}, r_error, 0);
    chk({tag, "_r_cycles"}, r_cycles, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic load_job1();
    clear_job();
    add_word(32'h0003_0005, 1'b0);
    add_word(32'h1111_1111, 1'b0);
    add_word(32'h2222_2222, 1'b0);
    add_word(32'h3333_3333, 1'b0);
    add_word(32'h4443_4241, 1'b0);
    add_word(32'h0000_0045, 1'b1);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    #1 chk("por_s_ready_low", s_ready, 0);
    @(posedge clk);
    #1 chk("por_s_ready_rise", s_ready, 1);

    // Accepted job with literal pins on memory, pointers and result.
    load_job1();
    run_job(0, 32'h0000_002A, 2, "accept");
    chk("lit_mem0", mem[0], 32'h1111_1111);
    chk("lit_mem3", mem[3], 32'h4443_4241);
    chk("lit_mem4", mem[4], 32'h0000_0045);
    chk("lit_start_cc", start_cc_pointer_register, 32'd12);
    chk("lit_end_cc", end_cc_pointer_register, 32'd16);
    chk("lit_accept", seen_acc, 1);
    chk("lit_cycles", seen_cyc, 32'h0000_002A);

    // Rejected job, result held for 10 cycles.
    load_job1();
    run_job(1, 32'h0000_0077, 10, "reject");
    chk("lit_reject_accept", seen_acc, 0);
    chk("lit_reject_cycles", seen_cyc, 32'h0000_0077);

    // Early s_last on code word 1, then a normal job.
    clear_job();
    add_word(32'h0003_0005, 1'b0);
    add_word(32'hAAAA_0000, 1'b0);
    add_word(32'hAAAA_0001, 1'b1);
    run_job(0, 32'd9, 0, "early_last");
    chk("lit_early_err", seen_err, 1);
    load_job1();
    run_job(0, 32'd5, 0, "after_early");

    // Zero code words: both words drained.
    clear_job();
    add_word(32'h0000_0004, 1'b0);
    add_word(32'hBBBB_0000, 1'b0);
    add_word(32'hBBBB_0001, 1'b1);
    run_job(0, 32'd7, 0, "zero_code");
    chk("lit_zero_code_err", seen_err, 1);

    // Status never RUNNING: start timeout.
    load_job1();
    run_job(2, 32'h0000_0099, 0, "timeout");
    chk("lit_timeout_err", seen_err, 1);
    chk("lit_timeout_cycles", seen_cyc, 32'd0);

    // Missing s_last on the final string word.
    clear_job();
    add_word(32'h0003_0005, 1'b0);
    for (int i = 0; i < 5; i++) add_word(32'hC000_0000 + 32'(i), 1'b0);
    add_word(32'hC000_00FF, 1'b1);
    run_job(0, 32'd3, 0, "missing_last");

    // Header carrying s_last, and a header one word over capacity.
    clear_job();
    add_word(32'h0003_0005, 1'b1);
    run_job(0, 32'd3, 0, "hdr_last");
    clear_job();
    add_word({16'd1020, 16'd20}, 1'b0);
    add_word(32'hDDDD_0000, 1'b1);
    run_job(0, 32'd3, 0, "too_big");

    // Exactly MEM_WORDS words, engine finishes while still in START.
    clear_job();
    add_word({16'd1, 16'd4092}, 1'b0);
    for (int i = 0; i < 1024; i++) add_word(32'h5000_0000 + 32'(i), i == 1023);
    run_job(3, 32'h0000_1234, 0, "full_mem");
    chk("lit_full_start_cc", start_cc_pointer_register, 32'd4);
    chk("lit_full_end_cc", end_cc_pointer_register, 32'd4095);
    chk("lit_full_accept", seen_acc, 1);

    // Reset asserted while waiting for the engine.
    load_job1();
    eng_mode = 4;
    eng_cycles = 32'd0;
    plan(4, 32'd0);
    cmp_en = 1'b1;
    foreach (wq[i]) send_word(wq[i], lq[i]);
    t = 0;
    while (!(status_register == STATUS_RUNNING && cmd_register == CMD_NOP) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reached_wait", status_register == STATUS_RUNNING && cmd_register == CMD_NOP, 1);
    chk("midrst_writes_done", exp_wr_addr.size(), 0);
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_s_ready_low", s_ready, 0);
    @(posedge clk);
    #1 chk("midrst_s_ready_rise", s_ready, 1);
    load_job1();
    run_job(0, 32'h0000_0042, 0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
